rv_plic_gateway: RTL

RV_PLIC_GATEWAY -- requirements
Module: rv_plic_gateway

---
 rtl/rv_plic_gateway.sv | 90 +++++++++
 1 files changed

// File: rtl/rv_plic_gateway.sv
// PLIC interrupt gateway: synchronizes raw sources, forms level/edge requests and
// tracks pending (ip) and in-service (ia) bits. Edge support under RV_PLIC_GATEWAY_EDGE_EN.
module rv_plic_gateway #(
  parameter int N_SOURCE = 32,
  localparam int SrcWidth = $clog2(N_SOURCE)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SOURCE-1:0] src_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic                claim_v_i,
  input  logic [SrcWidth-1:0] claim_id_i,
  input  logic                complete_v_i,
  input  logic [SrcWidth-1:0] complete_id_i,
  output logic [N_SOURCE-1:0] ip_o,
  output logic [N_SOURCE-1:0] ia_o
);

  // Source 0 is reserved: its ip/ia bits are masked off permanently.
  localparam logic [N_SOURCE-1:0] SrcMask = {{(N_SOURCE-1){1'b1}}, 1'b0};

  logic [N_SOURCE-1:0] s1_q, s2_q;
  logic [N_SOURCE-1:0] ip_q, ip_d;
  logic [N_SOURCE-1:0] ia_q, ia_d;
  logic [N_SOURCE-1:0] req;
  logic [N_SOURCE-1:0] pend_src;
  logic [N_SOURCE-1:0] claim_oh;
  logic [N_SOURCE-1:0] complete_oh;

  // Ids 0 and >= N_SOURCE never match a decoded bit, so illegal strobes are dropped.
  always_comb begin
    claim_oh    = '0;
    complete_oh = '0;
    for (int i = 1; i < N_SOURCE; i++) begin
      claim_oh[i]    = claim_v_i    && (claim_id_i    == SrcWidth'(i));
      complete_oh[i] = complete_v_i && (complete_id_i == SrcWidth'(i));
    end
  end

`ifdef RV_PLIC_GATEWAY_EDGE_EN
  logic [N_SOURCE-1:0] s3_q;
  logic [N_SOURCE-1:0] edge_pend_q, edge_pend_d;

  assign req = (le_i & s2_q & ~s3_q) | (~le_i & s2_q);

  // One-deep latch for edges that arrive while the source is in service.
  assign edge_pend_d = ia_q & (edge_pend_q | (req & le_i));
  assign pend_src    = req | edge_pend_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s3_q        <= '0;
      edge_pend_q <= '0;
    end else begin
      s3_q        <= s2_q;
      edge_pend_q <= edge_pend_d & SrcMask;
    end
  end
`else
  logic le_unused;

  assign le_unused = ^le_i;
  assign req       = s2_q;
  assign pend_src  = req;
`endif

  // Gating uses registered ia, so a completing source cannot re-pend in the same cycle.
  always_comb begin
    ip_d = ((ip_q | (pend_src & ~ia_q)) & ~claim_oh) & SrcMask;
    ia_d = ((ia_q & ~complete_oh) | claim_oh) & SrcMask;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
      ip_q <= '0;
      ia_q <= '0;
    end else begin
      s1_q <= src_i;
      s2_q <= s1_q;
      ip_q <= ip_d;
      ia_q <= ia_d;
    end
  end

  assign ip_o = ip_q;
  assign ia_o = ia_q;

endmodule
